// File: rtl/rx_serial_7e2_ascii_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_serial_7e2_ascii_if
// Purpose  : Bundles the serial input line and the character outputs of the
//            7E2 ASCII receiver.
// Signals  : RX        - serial line, idle high (driven by master)
//            ascii_out - last character or 7'h3F on error
//            pronto    - one-cycle pulse on each ascii_out update
//            erro      - error flag for the last frame
//            db_estado - receiver FSM state, for debug displays
// Modports : master - line driver / result consumer
//            slave  - the receiver itself
// Revision : 1.0 - initial release
// ============================================================================
interface rx_serial_7e2_ascii_if;
  logic       RX;
  logic [6:0] ascii_out;
  logic       pronto;
  logic       erro;
  logic [2:0] db_estado;

  modport master (output RX, input ascii_out, input pronto, input erro, input db_estado);
  modport slave  (input RX, output ascii_out, output pronto, output erro, output db_estado);
endinterface
`default_nettype wire

// File: rtl/rx_serial_7e2_ascii.sv
`default_nettype none
// ============================================================================
// Module   : rx_serial_7e2_ascii
// Purpose  : 7E2 asynchronous serial receiver (1 start, 7 data LSB-first,
//            even parity, 2 stop). Holds the last character as a 7-bit code;
//            corrupted frames are reported as ASCII '?' (7'h3F).
// Ports    : clock - system clock
//            reset - synchronous, active-high reset
//            bus   - rx_serial_7e2_ascii_if.slave (RX in; ascii_out, pronto,
//                    erro, db_estado out)
// Params   : CLK_FREQ (Hz), BAUD; DIV = CLK_FREQ/BAUD cycles per bit (>= 4)
// Macro    : RX_DIGIT_FILTER_EN - when defined, error-free frames outside
//            '0'..'9' are also reported as 7'h3F with erro=1.
// Revision : 1.0 - initial release
// ============================================================================
module rx_serial_7e2_ascii #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic                  clock,
  input  logic                  reset,
  rx_serial_7e2_ascii_if.slave  bus
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV + 1);

  localparam logic [CNT_W-1:0] C_FULL    = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] C_HALF    = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
  localparam logic [6:0]       ASCII_ERR = 7'h3F;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP1     = 3'd4,
    S_STOP2     = 3'd5,
    S_DONE      = 3'd6,
    S_WAIT_HIGH = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       shift_q, shift_d;
  logic [2:0]       bit_q, bit_d;
  logic             err_q, err_d;
  logic [6:0]       ascii_q, ascii_d;
  logic             erro_q, erro_d;
  logic             pronto_q, pronto_d;
  logic             rx_meta_q, rx_s_q;
  logic             tick;
  logic             frame_bad;

  // Two-stage synchronizer; resets to the idle-high level so reset never
  // looks like a start bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.RX;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      bit_q    <= '0;
      err_q    <= 1'b0;
      ascii_q  <= 7'h00;
      erro_q   <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      err_q    <= err_d;
      ascii_q  <= ascii_d;
      erro_q   <= erro_d;
      pronto_q <= pronto_d;
    end
  end

  // The counter is loaded with the distance to the next sample point and
  // the sample is taken in the cycle where it reaches 1.
  assign tick = (cnt_q == C_ONE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    err_d     = err_q;
    ascii_d   = ascii_q;
    erro_d    = erro_q;
    pronto_d  = 1'b0;
    frame_bad = err_q | ~rx_s_q;
`ifdef RX_DIGIT_FILTER_EN
    if ((shift_q < 7'h30) || (shift_q > 7'h39)) begin
      frame_bad = 1'b1;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = C_HALF;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rx_s_q) begin
            state_d = S_DATA;
            cnt_d   = C_FULL;
            bit_d   = 3'd0;
            err_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {rx_s_q, shift_q[6:1]};
          cnt_d   = C_FULL;
          if (bit_q == 3'd6) begin
            state_d = S_PARITY;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end
      S_PARITY: begin
        if (tick) begin
          err_d   = ^{shift_q, rx_s_q};
          cnt_d   = C_FULL;
          state_d = S_STOP1;
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end
      S_STOP1: begin
        if (tick) begin
          err_d   = err_q | ~rx_s_q;
          cnt_d   = C_FULL;
          state_d = S_STOP2;
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end
      S_STOP2: begin
        if (tick) begin
          // Result registers load on the edge into DONE, so they are valid
          // and pronto is high during the DONE cycle.
          err_d    = frame_bad;
          ascii_d  = frame_bad ? ASCII_ERR : shift_q;
          erro_d   = frame_bad;
          pronto_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end
      S_DONE: begin
        state_d = rx_s_q ? S_IDLE : S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        // A held-low line (break) must return high before a new start.
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.ascii_out = ascii_q;
  assign bus.erro      = erro_q;
  assign bus.pronto    = pronto_q;
  assign bus.db_estado = state_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_serial_7e2_ascii.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_serial_7e2_ascii
// Purpose  : Self-checking bench for rx_serial_7e2_ascii with DIV = 10.
//            Frames are built bit by bit from the 7E2 format rules and the
//            expected character/error flag is computed from those rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_serial_7e2_ascii;

  localparam int DIV = 10;

  logic clock;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_errors;

  rx_serial_7e2_ascii_if bus ();

  rx_serial_7e2_ascii #(
    .CLK_FREQ (1000),
    .BAUD     (100)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Every pronto-high sample is logged; a pulse wider than one cycle shows
  // up as an extra entry.
  logic [6:0] q_ascii[$];
  logic       q_erro[$];
  int         q_cyc[$];

  always @(negedge clock) begin
    if (bus.pronto === 1'b1) begin
      q_ascii.push_back(bus.ascii_out);
      q_erro.push_back(bus.erro);
      q_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference result of one frame from the format rules.
  function automatic logic [7:0] model(input logic [6:0] d, input logic par,
                                       input logic s1, input logic s2);
    logic bad;
    bad = ((^d) != par) || !s1 || !s2;
`ifdef RX_DIGIT_FILTER_EN
    if (!bad && (d < 7'h30 || d > 7'h39)) bad = 1'b1;
`endif
    return {bad, bad ? 7'h3F : d};
  endfunction

  // Sends one frame, then idles for gap cycles, then checks the result.
  task automatic send_frame(input string tag, input logic [6:0] d, input logic par_flip,
                            input logic s1, input logic s2, input int gap,
                            output int p_cyc);
    logic [10:0] fr;
    logic [7:0]  exp;
    logic        par;
    int          t0;
    int          n;
    par = (^d) ^ par_flip;
    fr  = {s2, s1, par, d, 1'b0};
    exp = model(d, par, s1, s2);
    t0  = cyc;
    for (int i = 0; i < 11; i++) begin
      bus.RX = fr[i];
      repeat (DIV) tick();
    end
    bus.RX = 1'b1;
    repeat (gap) tick();
    n = q_ascii.size();
    p_cyc = -1;
    check({tag, " pulses"}, n, 1);
    if (n > 0) begin
      p_cyc = q_cyc.pop_front();
      check({tag, " ascii"}, q_ascii.pop_front(), exp[6:0]);
      check({tag, " erro"}, q_erro.pop_front(), exp[7]);
      check({tag, " latency"}, int'((p_cyc - t0) >= 10 * DIV && (p_cyc - t0) <= 11 * DIV), 1);
    end
    q_ascii.delete();
    q_erro.delete();
    q_cyc.delete();
  endtask

  initial begin
    int p1, p2;
    logic [10:0] fr9;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    bus.RX   = 1'b1;
    reset    = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst ascii", bus.ascii_out, 7'h00);
    check("rst pronto", bus.pronto, 0);
    check("rst erro", bus.erro, 0);
    check("rst state", bus.db_estado, 0);
    repeat (DIV) tick();

    // Back-to-back '5' then '7'
    send_frame("c5", 7'h35, 1'b0, 1'b1, 1'b1, 0, p1);
    send_frame("c7", 7'h37, 1'b0, 1'b1, 1'b1, 2 * DIV, p2);
    check("b2b spacing", p2 - p1, 11 * DIV);

    // Parity error then valid '3'
    send_frame("par3", 7'h33, 1'b1, 1'b1, 1'b1, 2 * DIV, p1);
    send_frame("c3", 7'h33, 1'b0, 1'b1, 1'b1, 2 * DIV, p1);

    // Start glitch of 3 cycles
    bus.RX = 1'b0;
    repeat (3) tick();
    bus.RX = 1'b1;
    repeat (2 * DIV) tick();
    check("glitch pulses", q_ascii.size(), 0);
    check("glitch state", bus.db_estado, 0);

    // Break: line low for 15 bit times
    bus.RX = 1'b0;
    repeat (15 * DIV) tick();
    check("break pulses", q_ascii.size(), 1);
    if (q_ascii.size() > 0) begin
      check("break ascii", q_ascii[0], 7'h3F);
      check("break erro", q_erro[0], 1);
    end
    check("break wait", bus.db_estado, 7);
    bus.RX = 1'b1;
    repeat (5) tick();
    check("break idle", bus.db_estado, 0);
    q_ascii.delete();
    q_erro.delete();
    q_cyc.delete();
    repeat (DIV) tick();

    // Letter 'A' (filtered only when the digit filter is built in)
    send_frame("cA", 7'h41, 1'b0, 1'b1, 1'b1, 2 * DIV, p1);

    // Reset in the middle of a '9' frame
    fr9 = {1'b1, 1'b1, ^7'h39, 7'h39, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus.RX = fr9[i];
      repeat (DIV) tick();
    end
    reset  = 1'b1;
    bus.RX = 1'b1;
    tick();
    check("mid rst ascii", bus.ascii_out, 7'h00);
    check("mid rst erro", bus.erro, 0);
    check("mid rst state", bus.db_estado, 0);
    reset = 1'b0;
    repeat (12 * DIV) tick();
    check("mid rst pulses", q_ascii.size(), 0);
    q_ascii.delete();
    q_erro.delete();
    q_cyc.delete();
    send_frame("c9", 7'h39, 1'b0, 1'b1, 1'b1, 2 * DIV, p1);

    // Randomized frames: random data, occasional parity/stop faults
    for (int k = 0; k < 24; k++) begin
      logic [6:0] d;
      logic       pf, s1, s2;
      int         gap;
      d   = 7'($urandom_range(0, 127));
      if (k % 3 == 0) d = 7'($urandom_range(8'h30, 8'h39));
      pf  = ($urandom_range(0, 3) == 0);
      s1  = ($urandom_range(0, 7) != 0);
      s2  = ($urandom_range(0, 7) != 0);
      gap = (s2 && $urandom_range(0, 1) == 1) ? 0 : 2 * DIV;
      send_frame("rand", d, pf, s1, s2, gap, p1);
    end

    repeat (DIV) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_serial_7e2_ascii.md
# rx_serial_7e2_ascii

Asynchronous serial receiver, 7E2 format (1 start, 7 data LSB-first, even parity, 2 stop), that captures one ASCII character per frame and holds it as a 7-bit code. It sits directly upstream of the ASCII-to-7-segment decoder: its `ascii_out` drives the decoder's 7-bit input, and `pronto` marks each new character. Corrupted frames are presented as ASCII `?` (7'h3F), which the decoder shows as its error glyph.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115200: serial bit rate.
- `DIV` (localparam) = CLK_FREQ / BAUD, integer truncation; must be ≥ 4. This is the number of clock cycles per bit.
- `clock`  in  1  system clock. This is the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `RX`  in  1  serial line, idle high; asynchronous to `clock`.
- `ascii_out`  out  7  last received character, or 7'h3F on error; held until the next frame completes.
- `pronto`  out  1  one-cycle pulse when `ascii_out` is updated.
- `erro`  out  1  high if the last frame had a parity or stop-bit error; updated together with `ascii_out`.
- `db_estado`  out  3  current FSM state encoding, for debug displays.

## Operation
- `RX` passes through a 2-FF synchronizer. All logic uses the synchronized signal `rx_s`.
- FSM states and encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP1=4, STOP2=5, DONE=6, WAIT_HIGH=7.
- IDLE: when `rx_s`=0, go to START and load the bit counter with DIV/2.
- START: at the end of the count, sample `rx_s`. If it is 0, go to DATA and reload the counter with DIV. If it is 1, treat it as a glitch and return to IDLE with no output change.
- DATA: sample once every DIV cycles at mid-bit, 7 samples, shifting into a 7-bit register LSB-first. Then go to PARITY.
- PARITY: sample 1 bit. The parity check passes when the XOR of the 7 data bits and the parity bit equals 0 (even parity).
- STOP1, STOP2: sample 1 bit each. A sampled 0 is a stop-bit error.
- DONE: lasts one cycle. On entry, register `ascii_out` as follows: the data if there is no error, otherwise 7'h3F. Set `erro` to match and pulse `pronto`.
  - From DONE, go to IDLE if `rx_s`=1.
  - Otherwise go to WAIT_HIGH. WAIT_HIGH returns to IDLE only after `rx_s`=1, so a break condition never re-triggers start detection.
- A parity error combined with a stop error still yields one frame: a single `pronto` pulse, 7'h3F, and `erro`=1.
- No state other than DONE updates `ascii_out`, `erro` or `pronto`.

## Timing
- Reset values: `ascii_out`=7'h00 (the decoder shows blank), `pronto`=0, `erro`=0, FSM=IDLE, shift register and counter cleared.
- Reset asserted mid-frame: on the next edge, all registers take their reset values and the partial frame is discarded. Reception restarts on the next falling edge seen after reset deasserts.
- Synchronizer latency: 2 cycles from `RX` to `rx_s`.
- Start sample: DIV/2 cycles after `rx_s` falls.
- Each later sample: exactly DIV cycles after the previous one.
- `pronto` is high in the cycle immediately after the STOP2 sample and lasts exactly 1 cycle. `ascii_out` and `erro` become valid in that same cycle.
- Back-to-back frames: a start bit that begins directly after STOP2 is accepted. The time left in STOP2 after its mid-bit sample (about DIV/2) covers the DONE cycle.
- Baud error tolerance: mid-bit sampling with no resynchronization inside a frame.

## Configuration
- `RX_DIGIT_FILTER_EN`
  - Defined: a frame with no errors whose data is outside 7'h30–7'h39 is reported as 7'h3F with `erro`=1, so the display shows only digits or the error glyph.
  - Undefined: every error-free frame is passed through unchanged with `erro`=0.
- Timing, `pronto` behaviour and the FSM are identical in both builds.

## Test plan
Common setup: CLK_FREQ=1000 and BAUD=100, giving DIV=10.
1. Reset, then idle → `ascii_out`=7'h00, `pronto`=0, `erro`=0, `db_estado`=0.
2. Send '5' (7'h35, parity 0, stops 1,1) → one `pronto` pulse 1 cycle after the STOP2 sample, `ascii_out`=7'h35, `erro`=0. Immediately send '7' (7'h37, parity 1) back-to-back → `ascii_out`=7'h37 and a second pulse.
3. Send '3' (7'h33) with parity bit forced to 1 → `ascii_out`=7'h3F, `erro`=1. Then send a valid '3' → `ascii_out`=7'h33, `erro`=0.
4. Drive `RX` low for 3 cycles only → FSM returns to IDLE from START with no `pronto`. Then hold `RX` low for 15 bit times → one `pronto` with 7'h3F, FSM in WAIT_HIGH (7) until `RX`=1.
5. Assert `reset` during DATA of a '9' frame → outputs return to reset values and no `pronto` occurs. The next valid '9' gives 7'h39.
6. Send 'A' (7'h41, parity 0) → with `RX_DIGIT_FILTER_EN` defined: 7'h3F, `erro`=1. Without it: 7'h41, `erro`=0.
